flags_register: RTL and testbench
=================================

# flags_register

Architectural flags register: the writer side of the branch flags interface. It captures ALU status through a two-stage pipeline and executes explicit flag-manipulation instructions. It drives the 32-bit `flags` word consumed by the branch tester. Bits 3:0 are the condition bits addressed by a branch opcode's 4-bit mask.

## Interface
Parameters:
- none (widths fixed by the ISA: 32-bit flags, 32-bit ALU result)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- alu_valid  in  1  ALU result present this cycle
- alu_result  in  32  ALU result value
- alu_carry  in  1  ALU carry-out
- alu_overflow  in  1  ALU signed overflow
- flag_op_valid  in  1  explicit flag instruction present this cycle
- flag_op  in  2  00 set, 01 clear, 10 toggle, 11 load
- flag_mask  in  32  operand for flag_op
- flags  out  32  registered flags word to the branch tester
- flags_pending  out  1  ALU update in flight; branch decode stalls while high
- flags_changed  out  1  one-cycle pulse: flags changed at the last edge

## Operation
- Bit map:
  - bit0 Z
  - bit1 N
  - bit2 C
  - bit3 V
  - bit4 SV (sticky overflow)
  - bits 31:5 software flags
- Stage 1 (S1) registers, at the edge sampling alu_valid:
  - s1_valid
  - Z = (alu_result == 32'h0)
  - N = alu_result[31]
  - C = alu_carry
  - V = alu_overflow
- Stage 2 (commit), on the edge after S1 loads with s1_valid=1:
  - flags[3:0] <= {V,C,N,Z}
  - flags[4] <= flags[4] | V
  - bits 31:5 unchanged
- Explicit op commits at the edge sampling flag_op_valid:
  - set: flags |= mask
  - clear: flags &= ~mask
  - toggle: flags ^= mask
  - load: flags = mask
  - Applies to all 32 bits, including SV; clear or load is the only way to drop SV.
- Same-edge collision (S1 commit and flag_op_valid): S1 commit is older. Apply the ALU update first, then the explicit op to that result.
- alu_valid and flag_op_valid high in the same cycle: op commits at edge k, ALU at edge k+1. ALU bits 3:0 overwrite the op's effect there.
- Back-to-back alu_valid: fully pipelined, one commit per cycle, no bubbles.
- flags_pending = s1_valid, driven directly from the register.
- flags_changed = registered (next_flags != flags), high for exactly one cycle after any edge where the value changed. A commit that writes identical data gives no pulse.
- Reset:
  - clears flags to 32'h0, s1_valid to 0, flags_changed to 0
  - takes priority over every input
  - discards an ALU update in S1 (it never commits)

## Timing
- ALU path latency 2 edges: alu_valid sampled at edge k → flags updated at edge k+1.
- flags_pending is high between edges k and k+1.
- Explicit op latency 1 edge: sampled at edge k → flags updated at edge k.
- flags_changed is high during the cycle after the updating edge.
- All outputs registered; no combinational input→output paths.
- Reset values: flags=0, flags_pending=0, flags_changed=0.

## Test plan
- Reset, then idle 3 cycles → flags=0x00000000, flags_pending=0, flags_changed=0 throughout.
- alu_valid, alu_result=0, carry=1, overflow=0 at edge k → flags_pending=1 after k; flags=0x00000005 after k+1; flags_changed pulses one cycle.
- ALU result 0x80000000 with overflow=1 → flags=0x0000001A. Next ALU result 1, flags 0 → flags=0x00000010 (SV sticks). Then clear with mask 0x10 → flags=0x00000000.
- load mask 0xFFFF0000, then ALU result 0 → flags=0xFFFF0001. Then toggle mask 0x80000001 → 0x7FFF0000. Repeat the identical load → no flags_changed pulse.
- ALU at edge k, set mask 0x0000000F at edge k+1 → after k+1 flags=0x0000000F (op applied after ALU commit). With both valid at edge k instead → ALU bits 3:0 win after k+1.
- alu_valid at edge k, reset asserted at edge k+1 → flags=0, flags_pending=0; the ALU update never appears.

Source files
------------

// File: rtl/flags_register.sv
// Architectural flags register: two-stage ALU status capture plus set/clear/toggle/load ops.
// Latency: ALU 2 edges, explicit op 1 edge; no backpressure, consumers stall on flags_pending.
module flags_register (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [31:0] alu_result,
  input  logic        alu_carry,
  input  logic        alu_overflow,
  input  logic        flag_op_valid,
  input  logic [1:0]  flag_op,
  input  logic [31:0] flag_mask,
  output logic [31:0] flags,
  output logic        flags_pending,
  output logic        flags_changed
);

  typedef struct packed {
    logic v;
    logic c;
    logic n;
    logic z;
  } alu_flags_t;

  localparam logic [1:0] OP_SET    = 2'b00;
  localparam logic [1:0] OP_CLEAR  = 2'b01;
  localparam logic [1:0] OP_TOGGLE = 2'b10;
  localparam logic [1:0] OP_LOAD   = 2'b11;

  logic       s1_valid;
  alu_flags_t s1_dat;
  alu_flags_t alu_dat;
  logic [31:0] after_alu;
  logic [31:0] next_flags;

  always_comb begin
    alu_dat.z = (alu_result == 32'h0);
    alu_dat.n = alu_result[31];
    alu_dat.c = alu_carry;
    alu_dat.v = alu_overflow;
  end

  // The staged ALU update is older than a same-edge explicit op, so it lands first.
  always_comb begin
    after_alu = flags;
    if (s1_valid) begin
      after_alu[3:0] = s1_dat;
      after_alu[4]   = flags[4] | s1_dat.v;
    end
    next_flags = after_alu;
    if (flag_op_valid) begin
      case (flag_op)
        OP_SET:    next_flags = after_alu | flag_mask;
        OP_CLEAR:  next_flags = after_alu & ~flag_mask;
        OP_TOGGLE: next_flags = after_alu ^ flag_mask;
        OP_LOAD:   next_flags = flag_mask;
        default:   next_flags = after_alu;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid      <= 1'b0;
      s1_dat        <= '0;
      flags         <= 32'h0;
      flags_changed <= 1'b0;
    end else begin
      s1_valid      <= alu_valid;
      s1_dat        <= alu_dat;
      flags         <= next_flags;
      flags_changed <= (next_flags != flags);
    end
  end

  assign flags_pending = s1_valid;

endmodule

// File: tb/tb_flags_register.sv
// Directed bench for flags_register: per-cycle compare against a spec-level model plus literal checkpoints.
module tb_flags_register;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [31:0] alu_result;
  logic        alu_carry;
  logic        alu_overflow;
  logic        flag_op_valid;
  logic [1:0]  flag_op;
  logic [31:0] flag_mask;
  logic [31:0] flags;
  logic        flags_pending;
  logic        flags_changed;

  int total = 0;
  int bad   = 0;
  logic check_en = 1'b0;

  // Model state: architectural flags plus the one ALU result waiting to commit.
  logic [31:0] m_flags = 32'h0;
  logic        m_pend  = 1'b0;
  logic [3:0]  m_vcnz  = 4'h0;
  logic        m_chg   = 1'b0;

  flags_register dut (
    .clk           (clk),
    .reset         (reset),
    .alu_valid     (alu_valid),
    .alu_result    (alu_result),
    .alu_carry     (alu_carry),
    .alu_overflow  (alu_overflow),
    .flag_op_valid (flag_op_valid),
    .flag_op       (flag_op),
    .flag_mask     (flag_mask),
    .flags         (flags),
    .flags_pending (flags_pending),
    .flags_changed (flags_changed)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_next(input logic [31:0] f, input logic pend,
                                             input logic [3:0] vcnz, input logic opv,
                                             input logic [1:0] op, input logic [31:0] m);
    logic [31:0] r;
    r = f;
    if (pend) r = {f[31:5], f[4] | vcnz[3], vcnz};
    if (opv) begin
      if (op == 2'd0)      r = r | m;
      else if (op == 2'd1) r = r & ~m;
      else if (op == 2'd2) r = r ^ m;
      else                 r = m;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_flags <= 32'h0;
      m_pend  <= 1'b0;
      m_chg   <= 1'b0;
    end else begin
      m_flags <= model_next(m_flags, m_pend, m_vcnz, flag_op_valid, flag_op, flag_mask);
      m_chg   <= (model_next(m_flags, m_pend, m_vcnz, flag_op_valid, flag_op, flag_mask) != m_flags);
      m_pend  <= alu_valid;
      m_vcnz  <= {alu_overflow, alu_carry, alu_result[31], alu_result == 32'h0};
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("model flags", flags, m_flags);
      chk("model pending", {31'h0, flags_pending}, {31'h0, m_pend});
      chk("model changed", {31'h0, flags_changed}, {31'h0, m_chg});
    end
  end

  // Drive one cycle of inputs just after a falling edge; returns at the next falling edge.
  task automatic cyc(input logic av, input logic [31:0] res, input logic c, input logic o,
                     input logic fv, input logic [1:0] op, input logic [31:0] m);
    alu_valid     = av;
    alu_result    = res;
    alu_carry     = c;
    alu_overflow  = o;
    flag_op_valid = fv;
    flag_op       = op;
    flag_mask     = m;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
  endtask

  task automatic alu(input logic [31:0] res, input logic c, input logic o);
    cyc(1'b1, res, c, o, 1'b0, 2'd0, 32'h0);
  endtask

  task automatic fop(input logic [1:0] op, input logic [31:0] m);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, op, m);
  endtask

  initial begin
    reset = 1'b1;
    alu_valid = 1'b0; alu_result = 32'h0; alu_carry = 1'b0; alu_overflow = 1'b0;
    flag_op_valid = 1'b0; flag_op = 2'd0; flag_mask = 32'h0;
    @(negedge clk);
    check_en = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 3; i++) begin
      idle();
      chk("idle flags", flags, 32'h0);
      chk("idle pending", {31'h0, flags_pending}, 32'h0);
      chk("idle changed", {31'h0, flags_changed}, 32'h0);
    end

    alu(32'h0, 1'b1, 1'b0);
    chk("alu pending", {31'h0, flags_pending}, 32'h1);
    chk("alu not yet", flags, 32'h0);
    idle();
    chk("alu zero carry", flags, 32'h0000_0005);
    chk("alu pulse", {31'h0, flags_changed}, 32'h1);
    idle();
    chk("pulse one cycle", {31'h0, flags_changed}, 32'h0);

    alu(32'h8000_0000, 1'b0, 1'b1);
    idle();
    chk("neg overflow", flags, 32'h0000_001A);
    alu(32'h1, 1'b0, 1'b0);
    idle();
    chk("sv sticky", flags, 32'h0000_0010);
    fop(2'd1, 32'h10);
    chk("clear sv", flags, 32'h0);

    fop(2'd3, 32'hFFFF_0000);
    chk("load", flags, 32'hFFFF_0000);
    alu(32'h0, 1'b0, 1'b0);
    idle();
    chk("alu after load", flags, 32'hFFFF_0001);
    fop(2'd2, 32'h8000_0001);
    chk("toggle", flags, 32'h7FFF_0000);
    fop(2'd3, 32'hFFFF_0000);
    chk("reload pulse", {31'h0, flags_changed}, 32'h1);
    fop(2'd3, 32'hFFFF_0000);
    chk("same load no pulse", {31'h0, flags_changed}, 32'h0);

    fop(2'd3, 32'h0);
    alu(32'h5, 1'b0, 1'b0);
    fop(2'd0, 32'h0000_000F);
    chk("op after alu commit", flags, 32'h0000_000F);

    cyc(1'b1, 32'h5, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0000_00FF);
    chk("op first", flags, 32'h0000_00FF);
    idle();
    chk("alu wins low bits", flags, 32'h0000_00F0);

    // Back-to-back ALU results commit one per cycle.
    alu(32'h0, 1'b0, 1'b0);
    alu(32'h8000_0000, 1'b1, 1'b0);
    chk("b2b first", flags, 32'h0000_00F1);
    alu(32'h7, 1'b0, 1'b0);
    chk("b2b second", flags, 32'h0000_00F6);
    idle();
    chk("b2b third", flags, 32'h0000_00F0);

    alu(32'h0, 1'b1, 1'b1);
    reset = 1'b1;
    idle();
    chk("reset flags", flags, 32'h0);
    chk("reset pending", {31'h0, flags_pending}, 32'h0);
    reset = 1'b0;
    idle();
    chk("discarded alu", flags, 32'h0);
    chk("discarded changed", {31'h0, flags_changed}, 32'h0);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
